alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_mul.sv | 67 ++++++
 rtl/alu_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bundle.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_PASS = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_SAR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;

    // IDLE accepts operations; MUL waits for the iterative multiplier.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic err;
    } flags_t;

    // Opcodes 13..15 are unassigned and reported through err.
    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle.
// The first iteration happens on the start edge itself, so the full product
// is available (done=1) during the cycle after WIDTH-1 further edges.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic               active;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic [2*WIDTH-1:0] step_src;
    logic [WIDTH-1:0]   step_mcand;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_next;

    // One shift-add step: upper half accumulates the multiplicand when the
    // current low bit is set, then the whole register shifts right by one.
    // On start the step works directly on the incoming operands.
    always_comb begin
        step_src   = start ? {{WIDTH{1'b0}}, b} : prod;
        step_mcand = start ? a : mcand;
        step_sum   = {1'b0, step_src[2*WIDTH-1:WIDTH]}
                   + (step_src[0] ? {1'b0, step_mcand} : {(WIDTH+1){1'b0}});
        step_next  = {step_sum, step_src[WIDTH-1:1]};
    end

    // Iteration counter and product register; reset aborts any product in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            prod   <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= CW'(1);
            mcand  <= a;
            prod   <= step_next;
        end else if (active) begin
            if (count == LAST) begin
                active <= 1'b0;
            end else begin
                prod  <= step_next;
                count <= count + CW'(1);
            end
        end
    end

    assign done    = active && (count == LAST);
    assign product = prod;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops register their
// result on the accept edge; MUL hands off to the iterative multiplier and the
// result appears WIDTH edges later.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_hi,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             err,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t state;
    state_t state_next;

    logic               accept;
    logic               alu_load;
    logic               mul_start;
    logic               mul_done;
    logic               mul_load;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   mul_hi;

    logic [SHW-1:0]            sh_amt;
    logic                      carry_in;
    logic [WIDTH:0]            sum;
    logic [WIDTH:0]            diff;
    logic                      add_v;
    logic                      sub_v;
    logic [2*WIDTH-1:0]        shl_full;
    logic [2*WIDTH-1:0]        shr_full;
    logic signed [2*WIDTH-1:0] sar_full;
    logic [WIDTH-1:0]          alu_y;
    logic [WIDTH-1:0]          flag_val;
    logic                      alu_c;
    logic                      alu_v;
    flags_t                    alu_flags;

    // A new op may enter only when idle and the output slot is free or draining.
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign alu_load  = accept && (op != OP_MUL);
    assign mul_load  = (state == ST_MUL) && mul_done;
    assign busy      = (state == ST_MUL);
    assign mul_hi    = mul_product[2*WIDTH-1:WIDTH];

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register; reset drops any multiply in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enter MUL on an accepted multiply, return to IDLE once the product is in.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Single-cycle datapath. The stored C flag feeds ADC/SBC; add and subtract
    // are done one bit wider so the top bit is carry-out or borrow. Shifts go
    // through a double-width window so the last bit shifted out lands on a
    // fixed position. CMP takes its Z/N from the difference but returns A.
    always_comb begin
        sh_amt   = B[SHW-1:0];
        carry_in = C & ((op == OP_ADC) | (op == OP_SBC));
        sum      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
        diff     = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, carry_in};
        add_v    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        sub_v    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        shl_full = {{WIDTH{1'b0}}, A} << sh_amt;
        shr_full = {A, {WIDTH{1'b0}}} >> sh_amt;
        sar_full = $signed({A, {WIDTH{1'b0}}}) >>> sh_amt;

        alu_y    = '0;
        flag_val = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;

        case (op)
            OP_ADD, OP_ADC: begin
                alu_y    = sum[WIDTH-1:0];
                flag_val = alu_y;
                alu_c    = sum[WIDTH];
                alu_v    = add_v;
            end
            OP_SUB, OP_SBC: begin
                alu_y    = diff[WIDTH-1:0];
                flag_val = alu_y;
                alu_c    = diff[WIDTH];
                alu_v    = sub_v;
            end
            OP_CMP: begin
                alu_y    = A;
                flag_val = diff[WIDTH-1:0];
                alu_c    = diff[WIDTH];
                alu_v    = sub_v;
            end
            OP_AND: begin
                alu_y    = A & B;
                flag_val = alu_y;
            end
            OP_OR: begin
                alu_y    = A | B;
                flag_val = alu_y;
            end
            OP_XOR: begin
                alu_y    = A ^ B;
                flag_val = alu_y;
            end
            OP_PASS: begin
                alu_y    = A;
                flag_val = alu_y;
            end
            OP_SHL: begin
                alu_y    = shl_full[WIDTH-1:0];
                flag_val = alu_y;
                alu_c    = (sh_amt != '0) & shl_full[WIDTH];
            end
            OP_SHR: begin
                alu_y    = shr_full[2*WIDTH-1:WIDTH];
                flag_val = alu_y;
                alu_c    = (sh_amt != '0) & shr_full[WIDTH-1];
            end
            OP_SAR: begin
                alu_y    = sar_full[2*WIDTH-1:WIDTH];
                flag_val = alu_y;
                alu_c    = (sh_amt != '0) & sar_full[WIDTH-1];
            end
            OP_MUL: begin
                alu_y    = '0;
            end
            default: begin
                alu_y    = '0;
                flag_val = '0;
            end
        endcase

        alu_flags.z   = (flag_val == '0);
        alu_flags.n   = flag_val[WIDTH-1];
        alu_flags.c   = alu_c;
        alu_flags.v   = alu_v;
        alu_flags.err = !is_legal(op);
    end

    // Result register: loads on a single-cycle accept or multiplier completion,
    // otherwise holds; out_valid drops only when the consumer takes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Y         <= '0;
            Y_hi      <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            err       <= 1'b0;
        end else if (alu_load) begin
            out_valid <= 1'b1;
            Y         <= alu_y;
            Y_hi      <= '0;
            Z         <= alu_flags.z;
            N         <= alu_flags.n;
            C         <= alu_flags.c;
            V         <= alu_flags.v;
            err       <= alu_flags.err;
        end else if (mul_load) begin
            out_valid <= 1'b1;
            Y         <= mul_product[WIDTH-1:0];
            Y_hi      <= mul_hi;
            Z         <= (mul_product == '0);
            N         <= mul_product[WIDTH-1];
            C         <= (mul_hi != '0);
            V         <= (mul_hi != '0);
            err       <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
